// File: rtl/process_run_queue.sv
// Process run queue: a circular FIFO of runnable pids with a membership
// bitmap that rejects duplicates and the reserved pid 0, plus a time-slice
// timer that raises a preemption pulse when a slice ends and work is waiting.
module process_run_queue #(
  parameter int unsigned pidBits     = 5,
  parameter int unsigned depth       = 32,
  parameter int unsigned sliceCycles = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enqValid,
  input  logic [pidBits-1:0]        enqPid,
  output logic                      enqReady,
  input  logic                      deqRequest,
  output logic                      deqValid,
  output logic [pidBits-1:0]        deqPid,
  input  logic                      sliceStart,
  output logic                      sliceExpired,
  output logic [$clog2(depth):0]    count,
  output logic                      empty,
  output logic                      error
);

  localparam int unsigned AW   = $clog2(depth);
  localparam int unsigned NPID = 1 << pidBits;
  localparam logic [AW:0] FULL_COUNT   = (AW+1)'(depth);
  localparam logic [15:0] SLICE_RELOAD = 16'(sliceCycles - 1);

  typedef enum logic {
    S_IDLE,
    S_COUNTING
  } slice_state_t;

  logic [pidBits-1:0] r_mem [depth];
  logic [AW-1:0]      r_head;
  logic [AW-1:0]      r_tail;
  logic [AW:0]        r_count;
  logic [NPID-1:0]    r_bitmap;
  logic               r_deqValid;
  logic [pidBits-1:0] r_deqPid;
  logic               r_error;

  slice_state_t       r_state;
  logic [15:0]        r_timer;
  logic               r_sliceExpired;

  slice_state_t       w_nextState;
  logic [15:0]        w_nextTimer;
  logic               w_nextExpired;

  logic               w_full;
  logic               w_empty;
  logic               w_enqHs;
  logic               w_enqBad;
  logic               w_enqDo;
  logic               w_deqDo;
  logic [pidBits-1:0] w_headPid;

  assign w_full    = (r_count == FULL_COUNT);
  assign w_empty   = (r_count == '0);
  assign w_enqHs   = enqValid && !w_full;
  // Duplicate check reads the registered bitmap, so a pid leaving this cycle
  // is still treated as present.
  assign w_enqBad  = w_enqHs && ((enqPid == '0) || r_bitmap[enqPid]);
  assign w_enqDo   = w_enqHs && !w_enqBad;
  assign w_deqDo   = deqRequest && !w_empty;
  assign w_headPid = r_mem[r_head];

  assign enqReady     = !w_full;
  assign empty        = w_empty;
  assign count        = r_count;
  assign deqValid     = r_deqValid;
  assign deqPid       = r_deqPid;
  assign error        = r_error;
  assign sliceExpired = r_sliceExpired;

  // Queue storage write port; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (!reset && w_enqDo) begin
      r_mem[r_tail] <= enqPid;
    end
  end

  // Queue pointers, occupancy, membership bitmap, dequeue output and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_bitmap   <= '0;
      r_deqValid <= 1'b0;
      r_deqPid   <= '0;
      r_error    <= 1'b0;
    end else begin
      r_deqValid <= w_deqDo;
      if (w_deqDo) begin
        r_deqPid            <= w_headPid;
        r_head              <= r_head + 1'b1;
        r_bitmap[w_headPid] <= 1'b0;
      end
      // Accepted pid is never already in the bitmap, so it cannot collide
      // with the bit being cleared by a simultaneous dequeue.
      if (w_enqDo) begin
        r_tail           <= r_tail + 1'b1;
        r_bitmap[enqPid] <= 1'b1;
      end
      if (w_enqBad) begin
        r_error <= 1'b1;
      end
      case ({w_enqDo, w_deqDo})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Slice timer state, counter and registered preemption pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_timer        <= '0;
      r_sliceExpired <= 1'b0;
    end else begin
      r_state        <= w_nextState;
      r_timer        <= w_nextTimer;
      r_sliceExpired <= w_nextExpired;
    end
  end

  // Slice timer next-state: restart wins over expiry; an expiry with nothing
  // queued silently starts another slice instead of preempting.
  always_comb begin
    w_nextState   = r_state;
    w_nextTimer   = r_timer;
    w_nextExpired = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (sliceStart) begin
          w_nextState = S_COUNTING;
          w_nextTimer = SLICE_RELOAD;
        end
      end
      S_COUNTING: begin
        if (sliceStart) begin
          w_nextTimer = SLICE_RELOAD;
        end else if (r_timer != '0) begin
          w_nextTimer = r_timer - 16'd1;
        end else if (!w_empty) begin
          w_nextExpired = 1'b1;
          w_nextState   = S_IDLE;
        end else begin
          w_nextTimer = SLICE_RELOAD;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/process_run_queue.md
PROCESS_RUN_QUEUE -- requirements
Module: process_run_queue

Interface
REQ-001 Parameter pidBits, 5, width of a process id (one process per memory cell).
REQ-002 Parameter depth, 32, queue capacity; power of two; log2(depth) <= pidBits.
REQ-003 Parameter sliceCycles, 256, time-slice length in clock cycles; range 2..65535.
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 enqValid  in  1  producer presents a newly created or yielded pid.
REQ-007 enqPid  in  pidBits  pid to enqueue.
REQ-008 enqReady  out  1  queue can accept; combinational, equals !full.
REQ-009 deqRequest  in  1  scheduler requests the next runnable pid.
REQ-010 deqValid  out  1  registered; deqPid is valid this cycle.
REQ-011 deqPid  out  pidBits  registered dequeued pid.
REQ-012 sliceStart  in  1  pulse: a process has just been dispatched.
REQ-013 sliceExpired  out  1  registered one-cycle preemption pulse.
REQ-014 count  out  log2(depth)+1  number of queued pids.
REQ-015 empty  out  1  count == 0.
REQ-016 error  out  1  sticky flag: rejected enqueue.

Function
REQ-017 Storage SHALL be a circular buffer with head/tail pointers of log2(depth) bits wrapping modulo depth, plus a 2^pidBits-bit membership bitmap.
REQ-018 Enqueue SHALL occur when enqValid && enqReady; pid is written at tail, tail+1, count+1, bitmap[pid] set.
REQ-019 An enqueue handshake with enqPid == 0 (reserved) or with bitmap[enqPid] already set SHALL complete without storing and SHALL set error; count is unchanged.
REQ-020 Duplicate checks SHALL use the registered bitmap, so a pid being dequeued in the same cycle still counts as present.
REQ-021 When full, enqReady SHALL be 0 even if a dequeue occurs in the same cycle.
REQ-022 deqRequest with !empty SHALL, one cycle later, assert deqValid for exactly one cycle with deqPid = head entry; head+1, count-1, bitmap[pid] cleared at that edge.
REQ-023 deqRequest with empty SHALL yield deqValid = 0 the next cycle with no state change; a same-cycle enqueue into the empty queue is stored, not bypassed.
REQ-024 Simultaneous valid enqueue and dequeue with 0 < count < depth SHALL perform both; count unchanged.
REQ-025 deqPid SHALL hold its last value while deqValid = 0.
REQ-026 Slice timer FSM SHALL have states IDLE and COUNTING with a 16-bit down-counter.
REQ-027 IDLE --sliceStart--> COUNTING, counter loaded with sliceCycles-1.
REQ-028 In COUNTING, sliceStart SHALL reload the counter (restart the slice) and take priority over expiry.
REQ-029 In COUNTING with counter > 0, the counter SHALL decrement by 1 per cycle.
REQ-030 In COUNTING with counter == 0 and !empty: sliceExpired = 1 next cycle, FSM -> IDLE.
REQ-031 In COUNTING with counter == 0 and empty: no pulse; counter reloads with sliceCycles-1, FSM stays COUNTING.
REQ-032 sliceExpired SHALL therefore assert exactly sliceCycles cycles after sliceStart when the queue is non-empty throughout.

Reset
REQ-033 While reset = 1: head = tail = count = 0, bitmap cleared, deqValid = 0, deqPid = 0, sliceExpired = 0, error = 0, FSM = IDLE, counter = 0; enqReady = 1, empty = 1.
REQ-034 Reset asserted mid-operation SHALL discard all queued pids and any running slice within the same edge; handshakes in that cycle are ignored.
REQ-035 error SHALL clear only on reset.

Verification
REQ-036 Enqueue pids 3,7,1 then three deqRequests -> deqPid 3,7,1 on successive deqValid cycles; count 3->0; empty = 1.
REQ-037 Fill 31 distinct pids 1..31 into depth 32, enqueue pid 0 -> error = 1, count stays 31; with depth 4, fill 4 -> enqReady = 0, 5th enqValid not accepted.
REQ-038 Enqueue 5 twice -> count = 1, error = 1; dequeue 5, then enqueue 5 -> accepted, count = 1.
REQ-039 Empty queue, deqRequest + enqValid(pid 9) same cycle -> deqValid = 0 next cycle, count = 1; next deqRequest -> deqPid = 9.
REQ-040 sliceCycles = 4, queue holds pid 2, sliceStart at cycle 0 -> sliceExpired high only at cycle 4; with empty queue -> never pulses; sliceStart at cycle 2 -> pulse moves to cycle 6.
REQ-041 Queue holds 3 pids, slice running, reset pulsed -> count = 0, enqReady = 1, no sliceExpired afterward, error = 0.
